// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param: single-product vending controller.
// Accepts three coin values, dispenses once credit reaches PRICE, then
// returns the remainder (or a cancelled credit) as CHANGE_UNIT coins over a
// chg_req/chg_ack handshake.
// Optional inactivity refund is compiled in with `define VEND_TIMEOUT_EN.
module vending_ctrl_param #(
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned PRICE       = 15,
    parameter int unsigned COIN_A      = 5,
    parameter int unsigned COIN_B      = 10,
    parameter int unsigned COIN_C      = 25,
    parameter int unsigned CHANGE_UNIT = 5,
    parameter int unsigned MAX_CREDIT  = 100,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                coin_c,
    input  logic                cancel,
    input  logic                chg_ack,
    output logic                dispense,
    output logic                coin_reject,
    output logic                chg_req,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                timeout_o
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, CHANGE} state_t;

    // Reject configurations that would break the exact-change guarantee.
    if ((64'(MAX_CREDIT) >= (64'(1) << CREDIT_W)) || (PRICE > MAX_CREDIT) ||
        (CHANGE_UNIT == 0) || (PRICE % CHANGE_UNIT != 0) ||
        (COIN_A % CHANGE_UNIT != 0) || (COIN_B % CHANGE_UNIT != 0) ||
        (COIN_C % CHANGE_UNIT != 0) || (TIMEOUT_CYC == 0)) begin : g_bad_cfg
        $error("vending_ctrl_param: inconsistent parameter set");
    end

    state_t           state;
    logic             chg_q;
    logic [1:0]       coin_cnt;
    logic             coin_any;
    logic [SUM_W-1:0] coin_val;
    logic [SUM_W-1:0] sum;
    logic             accept;
    logic             expire;

    // Coin decode: value, widened sum and acceptance decision.
    always_comb begin
        coin_cnt = 2'({1'b0, coin_a}) + 2'({1'b0, coin_b}) + 2'({1'b0, coin_c});
        coin_any = coin_a | coin_b | coin_c;
        coin_val = '0;
        if (coin_a)      coin_val = SUM_W'(COIN_A);
        else if (coin_b) coin_val = SUM_W'(COIN_B);
        else if (coin_c) coin_val = SUM_W'(COIN_C);
        sum    = {1'b0, credit} + coin_val;
        accept = (coin_cnt == 2'd1) && !cancel && (state != CHANGE) &&
                 (sum <= SUM_W'(MAX_CREDIT));
    end

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    // Expiry only when nothing else moves the FSM this cycle; a coin wins.
    assign expire = (state == COLLECT) && !accept && !cancel &&
                    (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Inactivity counter: counts idle COLLECT cycles, cleared otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            if ((state == COLLECT) && !accept && !cancel && !expire)
                to_cnt <= to_cnt + TO_W'(1);
            else
                to_cnt <= '0;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Main FSM: credit accumulation, dispense, and change return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            dispense    <= 1'b0;
            coin_reject <= 1'b0;
            chg_q       <= 1'b0;
        end else begin
            dispense    <= 1'b0;
            coin_reject <= coin_any && !accept;
            case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (sum >= SUM_W'(PRICE)) begin
                            dispense <= 1'b1;
                            credit   <= CREDIT_W'(sum - SUM_W'(PRICE));
                            if (sum == SUM_W'(PRICE)) begin
                                state <= IDLE;
                                chg_q <= 1'b0;
                            end else begin
                                state <= CHANGE;
                                chg_q <= 1'b1;
                            end
                        end else begin
                            credit <= CREDIT_W'(sum);
                            state  <= COLLECT;
                        end
                    end else if ((state == COLLECT) && (cancel || expire)) begin
                        state <= CHANGE;
                        chg_q <= 1'b1;
                    end
                end
                CHANGE: begin
                    if (chg_ack) begin
                        credit <= credit - CREDIT_W'(CHANGE_UNIT);
                        if (credit == CREDIT_W'(CHANGE_UNIT)) begin
                            state <= IDLE;
                            chg_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    chg_q <= 1'b0;
                end
            endcase
        end
    end

    assign chg_req = chg_q;
    assign busy    = chg_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed bench for vending_ctrl_param: default instance, a PRICE=100
// instance for the credit ceiling, and (with VEND_TIMEOUT_EN) a short
// timeout instance.
module tb_vending_ctrl_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // Default-parameter instance
    logic       a0 = 0, b0 = 0, c0 = 0, can0 = 0, ack0 = 0;
    logic       disp0, rej0, req0, busy0, to0;
    logic [7:0] cr0;

    vending_ctrl_param u0 (
        .clk(clk), .rst(rst), .coin_a(a0), .coin_b(b0), .coin_c(c0),
        .cancel(can0), .chg_ack(ack0), .dispense(disp0), .coin_reject(rej0),
        .chg_req(req0), .credit(cr0), .busy(busy0), .timeout_o(to0)
    );

    // PRICE == MAX_CREDIT instance
    logic       a1 = 0, b1 = 0, c1 = 0, can1 = 0, ack1 = 0;
    logic       disp1, rej1, req1, busy1, to1;
    logic [7:0] cr1;

    vending_ctrl_param #(.PRICE(100), .MAX_CREDIT(100)) u1 (
        .clk(clk), .rst(rst), .coin_a(a1), .coin_b(b1), .coin_c(c1),
        .cancel(can1), .chg_ack(ack1), .dispense(disp1), .coin_reject(rej1),
        .chg_req(req1), .credit(cr1), .busy(busy1), .timeout_o(to1)
    );

`ifdef VEND_TIMEOUT_EN
    logic       a2 = 0, b2 = 0, c2 = 0, can2 = 0, ack2 = 0;
    logic       disp2, rej2, req2, busy2, to2;
    logic [7:0] cr2;

    vending_ctrl_param #(.TIMEOUT_CYC(8)) u2 (
        .clk(clk), .rst(rst), .coin_a(a2), .coin_b(b2), .coin_c(c2),
        .cancel(can2), .chg_ack(ack2), .dispense(disp2), .coin_reject(rej2),
        .chg_req(req2), .credit(cr2), .busy(busy2), .timeout_o(to2)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled at this edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_credit", 32'(cr0), 0);
        chk("rst_disp", 32'(disp0), 0);
        chk("rst_req", 32'(req0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_rej", 32'(rej0), 0);
        chk("rst_to", 32'(to0), 0);
        rst = 1'b0;
        tick();

        // 1: coin_a then coin_b -> exact price
        a0 = 1; tick(); a0 = 0;
        chk("t1_credit5", 32'(cr0), 5);
        chk("t1_nodisp", 32'(disp0), 0);
        b0 = 1; tick(); b0 = 0;
        chk("t1_disp", 32'(disp0), 1);
        chk("t1_credit0", 32'(cr0), 0);
        chk("t1_noreq", 32'(req0), 0);
        tick();
        chk("t1_disp_pulse", 32'(disp0), 0);
        chk("t1_noreq2", 32'(req0), 0);

        // 2: coin_c with ack held -> 10 change in two acked cycles
        c0 = 1; ack0 = 1; tick(); c0 = 0;
        chk("t2_disp", 32'(disp0), 1);
        chk("t2_credit10", 32'(cr0), 10);
        chk("t2_req", 32'(req0), 1);
        chk("t2_busy", 32'(busy0), 1);
        tick();
        chk("t2_credit5", 32'(cr0), 5);
        chk("t2_req_mid", 32'(req0), 1);
        tick();
        chk("t2_credit0", 32'(cr0), 0);
        chk("t2_req_off", 32'(req0), 0);
        chk("t2_busy_off", 32'(busy0), 0);
        ack0 = 0;
        tick();
        chk("t2_credit_hold", 32'(cr0), 0);

        // 3: coin_a, cancel two cycles later, one ack refunds
        a0 = 1; tick(); a0 = 0;
        chk("t3_credit5", 32'(cr0), 5);
        tick();
        can0 = 1; tick(); can0 = 0;
        chk("t3_req", 32'(req0), 1);
        chk("t3_nodisp", 32'(disp0), 0);
        chk("t3_credit_kept", 32'(cr0), 5);
        ack0 = 1; tick(); ack0 = 0;
        chk("t3_credit0", 32'(cr0), 0);
        chk("t3_req_off", 32'(req0), 0);
        can0 = 1; tick(); can0 = 0;
        chk("t3_idle_cancel_req", 32'(req0), 0);
        chk("t3_idle_cancel_cr", 32'(cr0), 0);

        // 4: double coin rejected; ack without req ignored; coin in CHANGE rejected
        a0 = 1; b0 = 1; tick(); a0 = 0; b0 = 0;
        chk("t4_rej_double", 32'(rej0), 1);
        chk("t4_credit_double", 32'(cr0), 0);
        ack0 = 1; tick(); ack0 = 0;
        chk("t4_rej_pulse", 32'(rej0), 0);
        chk("t4_stray_ack_cr", 32'(cr0), 0);
        chk("t4_stray_ack_req", 32'(req0), 0);
        c0 = 1; tick(); c0 = 0;
        chk("t4_change_cr", 32'(cr0), 10);
        b0 = 1; tick(); b0 = 0;
        chk("t4_rej_change", 32'(rej0), 1);
        chk("t4_change_cr_kept", 32'(cr0), 10);
        chk("t4_change_req_kept", 32'(req0), 1);

        // 6a: async reset mid-CHANGE, no clock edge in between
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_req", 32'(req0), 0);
        chk("t6_rst_busy", 32'(busy0), 0);
        chk("t6_rst_credit", 32'(cr0), 0);
        tick();
        rst = 1'b0;
        tick();

        // 5: credit ceiling on PRICE=100 instance
        c1 = 1; tick(); chk("t5_cr25", 32'(cr1), 25);
        tick(); chk("t5_cr50", 32'(cr1), 50);
        tick(); c1 = 0; chk("t5_cr75", 32'(cr1), 75);
        b1 = 1; tick(); b1 = 0; chk("t5_cr85", 32'(cr1), 85);
        c1 = 1; tick(); c1 = 0;
        chk("t5_rej_over", 32'(rej1), 1);
        chk("t5_cr85_kept", 32'(cr1), 85);
        b1 = 1; tick(); b1 = 0;
        chk("t5_cr95", 32'(cr1), 95);
        chk("t5_nodisp", 32'(disp1), 0);
        a1 = 1; tick(); a1 = 0;
        chk("t5_disp", 32'(disp1), 1);
        chk("t5_cr0", 32'(cr1), 0);
        chk("t5_noreq", 32'(req1), 0);
        chk("t5_busy", 32'(busy1), 0);
        chk("t5_to", 32'(to1), 0);

`ifdef VEND_TIMEOUT_EN
        // 6b: inactivity refund after 8 COLLECT cycles
        a2 = 1; tick(); a2 = 0;
        chk("t6_to_cr5", 32'(cr2), 5);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t6_to_early", 32'(to2), 0);
        end
        tick();
        chk("t6_to_pulse", 32'(to2), 1);
        chk("t6_to_req", 32'(req2), 1);
        chk("t6_to_cr", 32'(cr2), 5);
        ack2 = 1; tick(); ack2 = 0;
        chk("t6_to_pulse_end", 32'(to2), 0);
        chk("t6_to_refunded", 32'(cr2), 0);
        chk("t6_to_req_off", 32'(req2), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
